// File: rtl/prim_range_driver_pkg.sv
// Shared widths, power-of-ten table, digit counting and FSM encodings for the
// range driver and its block iterator.
package prim_range_driver_pkg;

   localparam int DATA_WIDTH      = 64;
   localparam int LONG_DATA_WIDTH = 128;
   localparam int MAX_DIGITS      = 20;

   typedef logic [DATA_WIDTH-1:0]      data_t;
   typedef logic [LONG_DATA_WIDTH-1:0] long_t;
   typedef logic [5:0]                 digit_t;
   typedef logic [2:0]                 state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_NEXT  = 3'd2;
   localparam state_t ST_ISSUE = 3'd3;
   localparam state_t ST_GAP   = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   // Held at full 128-bit width so 10^20 and its neighbours never overflow.
   localparam long_t POW10_TABLE [0:MAX_DIGITS] = '{
      128'd1,
      128'd10,
      128'd100,
      128'd1000,
      128'd10000,
      128'd100000,
      128'd1000000,
      128'd10000000,
      128'd100000000,
      128'd1000000000,
      128'd10000000000,
      128'd100000000000,
      128'd1000000000000,
      128'd10000000000000,
      128'd100000000000000,
      128'd1000000000000000,
      128'd10000000000000000,
      128'd100000000000000000,
      128'd1000000000000000000,
      128'd10000000000000000000,
      128'd100000000000000000000
   };

   function automatic long_t pow10(input digit_t k);
      logic [4:0] idx;
      idx = (k > digit_t'(MAX_DIGITS)) ? 5'(MAX_DIGITS) : k[4:0];
      return POW10_TABLE[idx];
   endfunction

   function automatic digit_t digits(input data_t x);
      digit_t n;
      n = 6'd1;
      for (int k = 1; k < MAX_DIGITS; k++) begin
         if (long_t'(x) >= POW10_TABLE[5'(k)]) n = n + 6'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/prim_range_driver_if.sv
// Range, job, result and sum channels between the range driver (master side)
// and its surroundings: range parser, prim_calc responder and sum consumer.
interface prim_range_driver_if;
   import prim_range_driver_pkg::*;

   logic  range_valid;
   logic  range_ready;
   data_t range_lo;
   data_t range_hi;

   logic       job_valid;
   data_t      job_base;
   data_t      job_block_size;
   data_t      job_ub;
   logic [1:0] job_r;

   logic  res_valid;
   long_t res_data;

   logic  sum_valid;
   logic  sum_ready;
   long_t sum_data;

   logic  err_timeout;
   logic  busy;

   modport master (
      input  range_valid, range_lo, range_hi, res_valid, res_data, sum_ready,
      output range_ready, job_valid, job_base, job_block_size, job_ub, job_r,
      output sum_valid, sum_data, err_timeout, busy
   );

   modport slave (
      output range_valid, range_lo, range_hi, res_valid, res_data, sum_ready,
      input  range_ready, job_valid, job_base, job_block_size, job_ub, job_r,
      input  sum_valid, sum_data, err_timeout, busy
   );

endinterface

// File: rtl/prim_range_driver_range_block_iter.sv
// Walks (digit count d, repetition r) candidates across a range and clamps
// each digit-length block to the range bounds.
module range_block_iter
   import prim_range_driver_pkg::*;
#(
   parameter int R_MAX = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic       advance,
   input  data_t      lo,
   input  data_t      hi,
   output logic       eligible,
   output logic       exhausted,
   output data_t      blk_base,
   output data_t      blk_ub,
   output digit_t     blk_d,
   output logic [1:0] blk_r
);

   digit_t     d_q, d_d;
   digit_t     dhi_q, dhi_d;
   logic [1:0] r_q, r_d;
   long_t      lower, upper;

   always_comb begin
      d_d   = d_q;
      r_d   = r_q;
      dhi_d = dhi_q;
      if (load) begin
         d_d   = digits(lo);
         r_d   = 2'd1;
         dhi_d = digits(hi);
      end else if (advance) begin
         if (r_q == 2'(R_MAX)) begin
            d_d = d_q + 6'd1;
            r_d = 2'd1;
         end else begin
            r_d = r_q + 2'd1;
         end
      end
   end

   // Repeated patterns only make sense for even block lengths longer than r.
   always_comb begin
      eligible  = (r_q == 2'd1) || ((digit_t'(r_q) < d_q) && !d_q[0]);
      exhausted = d_q > dhi_q;
      lower     = pow10(d_q - 6'd1);
      upper     = pow10(d_q) - long_t'(1);
      blk_base  = (long_t'(lo) > lower) ? lo : DATA_WIDTH'(lower);
      blk_ub    = (long_t'(hi) < upper) ? hi : DATA_WIDTH'(upper);
      blk_d     = d_q;
      blk_r     = r_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d_q   <= '0;
         r_q   <= '0;
         dhi_q <= '0;
      end else begin
         d_q   <= d_d;
         r_q   <= r_d;
         dhi_q <= dhi_d;
      end
   end

endmodule

// File: rtl/prim_range_driver.sv
// Request-side sequencer: splits one ID range into digit blocks, issues one
// job per eligible (d, r) pair and accumulates the responder's partial sums.
module prim_range_driver
   import prim_range_driver_pkg::*;
#(
   parameter int R_MAX       = 3,
   parameter int TIMEOUT_CYC = 256
) (
   input logic                 clock,
   input logic                 reset_n,
   prim_range_driver_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   state_t     state_q, state_d;
   data_t      lo_q, lo_d, hi_q, hi_d;
   long_t      acc_q, acc_d;
   logic       err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   data_t      job_base_q, job_base_d, job_ub_q, job_ub_d;
   digit_t     job_d_q, job_d_d;
   logic [1:0] job_r_q, job_r_d;

   logic       it_load, it_advance, it_eligible, it_exhausted;
   data_t      it_base, it_ub;
   digit_t     it_d;
   logic [1:0] it_r;

   assign it_load    = (state_q == ST_SETUP);
   assign it_advance = (state_q == ST_GAP) ||
                       ((state_q == ST_NEXT) && !it_exhausted && !it_eligible);

   range_block_iter #(.R_MAX(R_MAX)) u_iter (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (it_load),
      .advance   (it_advance),
      .lo        (lo_q),
      .hi        (hi_q),
      .eligible  (it_eligible),
      .exhausted (it_exhausted),
      .blk_base  (it_base),
      .blk_ub    (it_ub),
      .blk_d     (it_d),
      .blk_r     (it_r)
   );

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      acc_d      = acc_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      job_base_d = job_base_q;
      job_ub_d   = job_ub_q;
      job_d_d    = job_d_q;
      job_r_d    = job_r_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.range_valid) begin
               lo_d    = (bus.range_lo == '0) ? data_t'(1) : bus.range_lo;
               hi_d    = bus.range_hi;
               acc_d   = '0;
               err_d   = 1'b0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: state_d = (lo_q > hi_q) ? ST_DONE : ST_NEXT;
         ST_NEXT: begin
            if (it_exhausted) begin
               state_d = ST_DONE;
            end else if (it_eligible) begin
               job_base_d = it_base;
               job_ub_d   = it_ub;
               job_d_d    = it_d;
               job_r_d    = it_r;
               cnt_d      = '0;
               state_d    = ST_ISSUE;
            end
         end
         // A silent responder abandons the rest of the range; the partial sum stands.
         ST_ISSUE: begin
            if (bus.res_valid) begin
               acc_d   = acc_q + bus.res_data;
               state_d = ST_GAP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_GAP:  state_d = ST_NEXT;
         ST_DONE: if (bus.sum_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         lo_q       <= '0;
         hi_q       <= '0;
         acc_q      <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         job_base_q <= '0;
         job_ub_q   <= '0;
         job_d_q    <= '0;
         job_r_q    <= '0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         job_base_q <= job_base_d;
         job_ub_q   <= job_ub_d;
         job_d_q    <= job_d_d;
         job_r_q    <= job_r_d;
      end
   end

   // Handshake outputs decode the state register directly so reset drops them at once.
   assign bus.range_ready    = (state_q == ST_IDLE);
   assign bus.busy           = (state_q != ST_IDLE);
   assign bus.job_valid      = (state_q == ST_ISSUE);
   assign bus.job_base       = job_base_q;
   assign bus.job_ub         = job_ub_q;
   assign bus.job_block_size = {{(DATA_WIDTH-6){1'b0}}, job_d_q};
   assign bus.job_r          = job_r_q;
   assign bus.sum_valid      = (state_q == ST_DONE);
   assign bus.sum_data       = acc_q;
   assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_prim_range_driver.sv
// Scoreboard bench for prim_range_driver: a scripted responder answers jobs,
// expected jobs, gaps and sums are queued per scenario and popped on output.
module tb_prim_range_driver;
   import prim_range_driver_pkg::*;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      data_t      base;
      data_t      ub;
      data_t      d;
      logic [1:0] r;
   } job_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   prim_range_driver_if bus();

   prim_range_driver #(.R_MAX(3), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clock = ~clock;

   job_t  exp_job_q [$];
   long_t resp_q    [$];
   long_t exp_sum_q [$];
   int    exp_gap_q [$];
   int    errors = 0;
   int    checks = 0;

   task automatic push_job(input data_t base, input data_t ub, input data_t d, input logic [1:0] r);
      job_t j;
      j.base = base; j.ub = ub; j.d = d; j.r = r;
      exp_job_q.push_back(j);
   endtask

   // Offers one range, plays the responder cycle by cycle and checks against the queues.
   task automatic run_range(input data_t lo, input data_t hi, input int delay, input bit silent,
                            input bit stray, input int hold, input logic exp_err,
                            output int lat_sum, output int to_cyc);
      job_t  cur, held_job, exp;
      long_t held_sum, exp_sum;
      bit    prev_job = 0, seen_job = 0, done = 0;
      int    wait_cnt = 0, low_cnt = 0, cyc = 0, rise_cyc = 0, unstable = 0, sum_unstable = 0, exp_gap;
      lat_sum = -1;
      to_cyc  = -1;
      @(negedge clock);
      bus.range_lo = lo; bus.range_hi = hi; bus.range_valid = 1'b1;
      @(negedge clock);
      bus.range_valid = 1'b0;
      while (!done && cyc < 1000) begin
         cyc++;
         bus.res_valid = 1'b0;
         bus.res_data  = '0;
         if (bus.job_valid) begin
            cur.base = bus.job_base; cur.ub = bus.job_ub; cur.d = bus.job_block_size; cur.r = bus.job_r;
            if (!prev_job) begin
               rise_cyc = cyc;
               wait_cnt = 0;
               if (seen_job) begin
                  checks++;
                  exp_gap = (exp_gap_q.size() > 0) ? exp_gap_q.pop_front() : -1;
                  if (low_cnt != exp_gap) begin
                     errors++;
                     $display("[TB] FAIL job_gap: low for %0d cycles, expected %0d", low_cnt, exp_gap);
                  end
               end
               seen_job = 1;
               low_cnt  = 0;
               held_job = cur;
               checks++;
               if (exp_job_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_job: base=%0d ub=%0d d=%0d r=%0d", cur.base, cur.ub, cur.d, cur.r);
               end else begin
                  exp = exp_job_q.pop_front();
                  if (cur !== exp) begin
                     errors++;
                     $display("[TB] FAIL job_fields: got base=%0d ub=%0d d=%0d r=%0d, expected base=%0d ub=%0d d=%0d r=%0d",
                              cur.base, cur.ub, cur.d, cur.r, exp.base, exp.ub, exp.d, exp.r);
                  end
               end
            end else if (cur !== held_job) begin
               unstable++;
            end
            if (!silent && wait_cnt == delay - 1 && resp_q.size() > 0) begin
               bus.res_valid = 1'b1;
               bus.res_data  = resp_q.pop_front();
            end
            wait_cnt++;
         end else begin
            low_cnt++;
            if (stray) begin
               bus.res_valid = 1'b1;
               bus.res_data  = 128'd1000;
            end
         end
         if (bus.err_timeout && to_cyc < 0 && seen_job) to_cyc = cyc - rise_cyc;
         if (bus.sum_valid) begin
            lat_sum = cyc;
            exp_sum = (exp_sum_q.size() > 0) ? exp_sum_q.pop_front() : '1;
            checks++;
            if (bus.sum_data !== exp_sum) begin
               errors++;
               $display("[TB] FAIL sum_data: got %0d expected %0d", bus.sum_data, exp_sum);
            end
            checks++;
            if (bus.err_timeout !== exp_err) begin
               errors++;
               $display("[TB] FAIL err_timeout: got %0b expected %0b", bus.err_timeout, exp_err);
            end
            held_sum = bus.sum_data;
            for (int h = 0; h < hold; h++) begin
               @(negedge clock);
               if (!bus.sum_valid || bus.sum_data !== held_sum) sum_unstable++;
            end
            if (hold > 0) begin
               checks++;
               if (sum_unstable != 0) begin
                  errors++;
                  $display("[TB] FAIL sum_hold: %0d unstable cycles, expected 0", sum_unstable);
               end
            end
            bus.sum_ready = 1'b1;
            @(negedge clock);
            bus.sum_ready = 1'b0;
            checks++;
            if (bus.range_ready !== 1'b1 || bus.sum_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL sum_release: range_ready=%0b sum_valid=%0b, expected 1 and 0",
                        bus.range_ready, bus.sum_valid);
            end
            done = 1;
         end
         prev_job = bus.job_valid;
         if (!done) @(negedge clock);
      end
      bus.res_valid = 1'b0;
      if (!done) begin
         errors++;
         $display("[TB] FAIL range_timeout: no sum after %0d cycles for %0d..%0d", cyc, lo, hi);
      end
      checks++;
      if (exp_job_q.size() != 0 || unstable != 0) begin
         errors++;
         $display("[TB] FAIL job_bookkeeping: %0d jobs missing, %0d unstable cycles, expected 0 and 0",
                  exp_job_q.size(), unstable);
      end
      exp_job_q.delete(); resp_q.delete(); exp_sum_q.delete(); exp_gap_q.delete();
   endtask

   task automatic test_reset();
      bus.range_valid = 1'b0; bus.range_lo = '0; bus.range_hi = '0;
      bus.res_valid = 1'b0; bus.res_data = '0; bus.sum_ready = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (bus.range_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready_busy: got %0b/%0b expected 1/0", bus.range_ready, bus.busy);
      end
      checks++;
      if (bus.job_valid !== 1'b0 || bus.sum_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: job=%0b sum=%0b err=%0b expected 0", bus.job_valid, bus.sum_valid, bus.err_timeout);
      end
      checks++;
      if (bus.sum_data !== '0 || bus.job_base !== '0 || bus.job_ub !== '0 || bus.job_r !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_data: sum=%0d base=%0d ub=%0d r=%0d expected 0", bus.sum_data, bus.job_base, bus.job_ub, bus.job_r);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single();
      int lat, to;
      push_job(64'd11, 64'd22, 64'd2, 2'd1);
      resp_q.push_back(128'd33);
      exp_sum_q.push_back(128'd33);
      run_range(64'd11, 64'd22, 4, 0, 0, 0, 1'b0, lat, to);
   endtask

   task automatic test_cross_decade();
      int lat, to;
      push_job(64'd95, 64'd99, 64'd2, 2'd1);
      push_job(64'd100, 64'd115, 64'd3, 2'd1);
      resp_q.push_back(128'd99);
      resp_q.push_back(128'd111);
      exp_gap_q.push_back(4);
      exp_sum_q.push_back(128'd210);
      run_range(64'd95, 64'd115, 1, 0, 0, 0, 1'b0, lat, to);
   endtask

   task automatic test_repeat();
      int lat, to;
      for (int r = 1; r <= 3; r++) push_job(64'd1000, 64'd1200, 64'd4, 2'(r));
      resp_q.push_back(128'd5);
      resp_q.push_back(128'd7);
      resp_q.push_back(128'd11);
      exp_gap_q.push_back(2);
      exp_gap_q.push_back(2);
      exp_sum_q.push_back(128'd23);
      run_range(64'd1000, 64'd1200, 4, 0, 1, 0, 1'b0, lat, to);
   endtask

   task automatic test_max_digits();
      int lat, to;
      for (int r = 1; r <= 3; r++) push_job(64'd10000000000000000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd20, 2'(r));
      resp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
      resp_q.push_back(128'd2);
      resp_q.push_back(128'd3);
      exp_gap_q.push_back(2);
      exp_gap_q.push_back(2);
      exp_sum_q.push_back(128'd4);
      run_range(64'd10000000000000000000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 0, 1'b0, lat, to);
   endtask

   task automatic test_empty();
      int lat, to;
      exp_sum_q.push_back(128'd0);
      run_range(64'd50, 64'd10, 1, 0, 0, 0, 1'b0, lat, to);
      checks++;
      if (lat < 1 || lat > 3) begin
         errors++;
         $display("[TB] FAIL empty_latency: sum after %0d cycles, expected 1..3", lat);
      end
   endtask

   task automatic test_timeout();
      int lat, to;
      push_job(64'd11, 64'd22, 64'd2, 2'd1);
      exp_sum_q.push_back(128'd0);
      run_range(64'd11, 64'd22, 4, 1, 0, 0, 1'b1, lat, to);
      checks++;
      if (to != TIMEOUT) begin
         errors++;
         $display("[TB] FAIL timeout_latency: err after %0d cycles, expected %0d", to, TIMEOUT);
      end
      exp_sum_q.push_back(128'd0);
      run_range(64'd50, 64'd10, 1, 0, 0, 0, 1'b0, lat, to);
   endtask

   task automatic test_backpressure();
      int lat, to;
      push_job(64'd1, 64'd5, 64'd1, 2'd1);
      resp_q.push_back(128'd7);
      exp_sum_q.push_back(128'd7);
      run_range(64'd0, 64'd5, 3, 0, 0, 5, 1'b0, lat, to);
   endtask

   task automatic test_reset_mid_issue();
      int guard = 0;
      @(negedge clock);
      bus.range_lo = 64'd11; bus.range_hi = 64'd22; bus.range_valid = 1'b1;
      @(negedge clock);
      bus.range_valid = 1'b0;
      while (!bus.job_valid && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      checks++;
      if (bus.job_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_job_start: job_valid=%0b expected 1", bus.job_valid);
      end
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.job_valid !== 1'b0 || bus.busy !== 1'b0 || bus.range_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_async: job=%0b busy=%0b ready=%0b expected 0/0/1",
                  bus.job_valid, bus.busy, bus.range_ready);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.range_ready !== 1'b1 || bus.job_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_release: ready=%0b job=%0b expected 1/0", bus.range_ready, bus.job_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_cross_decade();
      test_repeat();
      test_max_digits();
      test_empty();
      test_timeout();
      test_backpressure();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
